ucie_ctl_rx_link_ctrl: RTL and testbench
========================================

// Module: ucie_ctl_rx_link_ctrl
// PURPOSE
// Sequences the RX datapath (RX buffer) through link states on behalf of the adapter state handler.
// Accepts state requests, gates buffer enable, drains in-flight RDI traffic before retrain/reset,
// issues buffer flush, and escalates buffer overflow to a sticky LINKERROR. Sits beside the RX buffer inside the RX top.
// PARAMETERS
// DRAIN_IDLE     4   consecutive idle (i_rdi_pl_valid=0) cycles that end DRAIN
// DRAIN_TIMEOUT  64  max cycles in DRAIN before forced LINKERROR
// RETRAIN_CYCLES 16  cycles spent in RETRAIN before auto-return to ACTIVE
// PORTS
// i_clk                input   1  clock
// i_rst                input   1  reset, asynchronous, active-low
// i_req_valid          input   1  request strobe, sampled each cycle
// i_req_state          input   2  0=NOP 1=ACTIVE 2=LINKRESET 3=RETRAIN
// i_rdi_pl_valid       input   1  RDI data valid, used only for drain-idle detection
// i_overflow_detected  input   1  overflow pulse from RX buffer
// o_buffer_enable      output  1  RX buffer enable
// o_buffer_flush       output  1  one-cycle flush pulse to RX buffer
// o_req_ack            output  1  one-cycle pulse: request accepted
// o_req_nak            output  1  one-cycle pulse: request rejected
// o_state_status       output  3  0=RESET 1=ACTIVE 2=DRAIN 3=RETRAIN 4=LINKERROR
// o_overflow_detected  output  1  sticky overflow/error flag
// BEHAVIOUR
// - Reset (i_rst=0, async): state RESET; all outputs 0; counters 0; drain target cleared.
// - All outputs registered; ack/nak/flush assert the cycle after the triggering sample, for one cycle.
// - RESET: enable=0. req ACTIVE -> ACTIVE, ack. req LINKRESET -> stay, ack. req RETRAIN -> nak.
// - ACTIVE: enable=1. req RETRAIN/LINKRESET -> DRAIN, record target, ack, clear counters.
//   req ACTIVE -> ack, stay. Overflow -> LINKERROR (overflow wins over a same-cycle request; no ack).
// - DRAIN: enable=1. idle_cnt increments on i_rdi_pl_valid=0, resets to 0 on valid=1.
//   idle_cnt reaches DRAIN_IDLE -> target state, flush pulse. tmo_cnt reaches DRAIN_TIMEOUT
//   -> LINKERROR. If idle and timeout hit same cycle, idle wins. Overflow -> LINKERROR.
//   Any request while in DRAIN -> nak.
// - RETRAIN: enable=0. ret_cnt counts 0..RETRAIN_CYCLES-1, then -> ACTIVE (no ack).
//   req LINKRESET -> RESET, flush, ack (abort). Other requests -> nak.
// - LINKERROR: enable=0; o_overflow_detected=1 on entry, held. Only req LINKRESET exits ->
//   RESET, flush, ack, sticky cleared same cycle. Other requests -> nak. Overflow ignored here.
// - NOP (req_valid=1, state=0) and req_valid=0: no ack, no nak.
// - Counters sized $clog2(param+1), saturate; never wrap.
// - Reset mid-DRAIN/RETRAIN: immediate return to RESET, no flush pulse generated.
// TESTING
// 1. Reset, req ACTIVE -> ack 1 cycle later, status=1, enable=1; req RETRAIN with valid=0
//    -> DRAIN, after 4 idle cycles flush pulse, status=3, 16 cycles later status=1.
// 2. ACTIVE, req LINKRESET, valid high 3 cycles then low -> idle_cnt restarts, exit after 4 idle
//    cycles to RESET with one flush pulse, enable=0.
// 3. DRAIN with valid held 1 for 64 cycles -> status=4, o_overflow_detected=1, no flush.
// 4. ACTIVE: overflow and req RETRAIN same cycle -> LINKERROR, no ack; req ACTIVE -> nak;
//    req LINKRESET -> RESET, flush, ack, sticky cleared.
// 5. RESET: req RETRAIN -> nak; in RETRAIN req ACTIVE -> nak, req LINKRESET -> RESET, ack, flush.
// 6. Assert i_rst at cycle 8 of RETRAIN -> all outputs 0 asynchronously, status=0 after release.

Source files
------------

// File: rtl/ucie_ctl_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// ucie_ctl_rx_link_ctrl
// Sequences the RX buffer through link states for the adapter state handler:
// accepts state requests, gates the buffer enable, drains in-flight RDI
// traffic before retrain/link-reset, pulses a buffer flush, and escalates
// buffer overflow or drain timeout to a sticky LINKERROR.
//
// Ports
//   i_clk               clock
//   i_rst               asynchronous active-low reset
//   i_req_valid         request strobe, sampled every cycle
//   i_req_state         0=NOP 1=ACTIVE 2=LINKRESET 3=RETRAIN
//   i_rdi_pl_valid      RDI data valid (drain-idle detection only)
//   i_overflow_detected overflow pulse from the RX buffer
//   o_buffer_enable     RX buffer enable
//   o_buffer_flush      one-cycle flush pulse
//   o_req_ack           one-cycle request-accepted pulse
//   o_req_nak           one-cycle request-rejected pulse
//   o_state_status      0=RESET 1=ACTIVE 2=DRAIN 3=RETRAIN 4=LINKERROR
//   o_overflow_detected sticky overflow/error flag (high while in LINKERROR)
// All outputs are registered and reflect the state entered on the last edge.
// ---------------------------------------------------------------------------
module ucie_ctl_rx_link_ctrl #(
    parameter int DRAIN_IDLE     = 4,
    parameter int DRAIN_TIMEOUT  = 64,
    parameter int RETRAIN_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    input  logic [1:0] i_req_state,
    input  logic       i_rdi_pl_valid,
    input  logic       i_overflow_detected,
    output logic       o_buffer_enable,
    output logic       o_buffer_flush,
    output logic       o_req_ack,
    output logic       o_req_nak,
    output logic [2:0] o_state_status,
    output logic       o_overflow_detected
);

    localparam int IDLE_W = $clog2(DRAIN_IDLE + 1);
    localparam int TMO_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int RET_W  = $clog2(RETRAIN_CYCLES + 1);

    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(DRAIN_IDLE);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(DRAIN_TIMEOUT);
    localparam logic [RET_W-1:0]  RET_LAST = RET_W'(RETRAIN_CYCLES - 1);

    localparam logic [1:0] REQ_NOP       = 2'd0;
    localparam logic [1:0] REQ_ACTIVE    = 2'd1;
    localparam logic [1:0] REQ_LINKRESET = 2'd2;
    localparam logic [1:0] REQ_RETRAIN   = 2'd3;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_ACTIVE    = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_RETRAIN   = 3'd3,
        ST_LINKERROR = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              target_retrain_r, target_nxt_s;   // 1: drain ends in RETRAIN, 0: in RESET
    logic [IDLE_W-1:0] idle_cnt_r, idle_nxt_s;
    logic [TMO_W-1:0]  tmo_cnt_r, tmo_nxt_s;
    logic [RET_W-1:0]  ret_cnt_r, ret_nxt_s;
    logic              ack_s, nak_s, flush_s;
    logic              req_real_s;

    // A valid request other than NOP; these are the ones that earn an ack or nak.
    assign req_real_s = i_req_valid && (i_req_state != REQ_NOP);

    // Next-state, counter and pulse decode.
    always_comb begin
        state_nxt_s  = state_r;
        target_nxt_s = target_retrain_r;
        idle_nxt_s   = idle_cnt_r;
        tmo_nxt_s    = tmo_cnt_r;
        ret_nxt_s    = ret_cnt_r;
        ack_s        = 1'b0;
        nak_s        = 1'b0;
        flush_s      = 1'b0;
        case (state_r)
            ST_RESET: begin
                if (i_req_valid) begin
                    case (i_req_state)
                        REQ_ACTIVE: begin
                            state_nxt_s = ST_ACTIVE;
                            ack_s       = 1'b1;
                        end
                        REQ_LINKRESET: ack_s = 1'b1;
                        REQ_RETRAIN:   nak_s = 1'b1;
                        default:       state_nxt_s = state_r;
                    endcase
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ACTIVE: begin
                // Overflow pre-empts a same-cycle request and suppresses its ack.
                if (i_overflow_detected) begin
                    state_nxt_s = ST_LINKERROR;
                end else if (i_req_valid) begin
                    case (i_req_state)
                        REQ_ACTIVE: ack_s = 1'b1;
                        REQ_LINKRESET, REQ_RETRAIN: begin
                            state_nxt_s  = ST_DRAIN;
                            target_nxt_s = (i_req_state == REQ_RETRAIN);
                            idle_nxt_s   = {IDLE_W{1'b0}};
                            tmo_nxt_s    = {TMO_W{1'b0}};
                            ack_s        = 1'b1;
                        end
                        default: state_nxt_s = state_r;
                    endcase
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN: begin
                nak_s      = req_real_s;
                idle_nxt_s = i_rdi_pl_valid ? {IDLE_W{1'b0}}
                           : ((idle_cnt_r == IDLE_MAX) ? idle_cnt_r : idle_cnt_r + 1'b1);
                tmo_nxt_s  = (tmo_cnt_r == TMO_MAX) ? tmo_cnt_r : tmo_cnt_r + 1'b1;
                // Idle completion is tested before timeout so it wins a tie.
                if (i_overflow_detected) begin
                    state_nxt_s = ST_LINKERROR;
                end else if (idle_nxt_s == IDLE_MAX) begin
                    state_nxt_s = target_retrain_r ? ST_RETRAIN : ST_RESET;
                    ret_nxt_s   = {RET_W{1'b0}};
                    flush_s     = 1'b1;
                end else if (tmo_nxt_s == TMO_MAX) begin
                    state_nxt_s = ST_LINKERROR;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RETRAIN: begin
                if (i_req_valid && (i_req_state == REQ_LINKRESET)) begin
                    state_nxt_s = ST_RESET;
                    flush_s     = 1'b1;
                    ack_s       = 1'b1;
                end else begin
                    nak_s = req_real_s;
                    if (ret_cnt_r == RET_LAST) begin
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        ret_nxt_s = ret_cnt_r + 1'b1;
                    end
                end
            end
            ST_LINKERROR: begin
                if (i_req_valid && (i_req_state == REQ_LINKRESET)) begin
                    state_nxt_s = ST_RESET;
                    flush_s     = 1'b1;
                    ack_s       = 1'b1;
                end else begin
                    nak_s = req_real_s;
                end
            end
            default: state_nxt_s = ST_RESET;
        endcase
    end

    // State, counters and registered outputs; outputs track the state being entered.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r             <= ST_RESET;
            target_retrain_r    <= 1'b0;
            idle_cnt_r          <= {IDLE_W{1'b0}};
            tmo_cnt_r           <= {TMO_W{1'b0}};
            ret_cnt_r           <= {RET_W{1'b0}};
            o_buffer_enable     <= 1'b0;
            o_buffer_flush      <= 1'b0;
            o_req_ack           <= 1'b0;
            o_req_nak           <= 1'b0;
            o_state_status      <= 3'd0;
            o_overflow_detected <= 1'b0;
        end else begin
            state_r             <= state_nxt_s;
            target_retrain_r    <= target_nxt_s;
            idle_cnt_r          <= idle_nxt_s;
            tmo_cnt_r           <= tmo_nxt_s;
            ret_cnt_r           <= ret_nxt_s;
            o_buffer_enable     <= (state_nxt_s == ST_ACTIVE) || (state_nxt_s == ST_DRAIN);
            o_buffer_flush      <= flush_s;
            o_req_ack           <= ack_s;
            o_req_nak           <= nak_s;
            o_state_status      <= state_nxt_s;
            o_overflow_detected <= (state_nxt_s == ST_LINKERROR);
        end
    end

endmodule

// File: tb/tb_ucie_ctl_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ucie_ctl_rx_link_ctrl
// Directed stimulus for ucie_ctl_rx_link_ctrl. Each expected ack/nak/flush
// pulse is queued together with the state view expected alongside it; a
// monitor pops and compares whenever the DUT shows a pulse. Quiet-time state
// views are checked directly by the stimulus thread.
// ---------------------------------------------------------------------------
module tb_ucie_ctl_rx_link_ctrl;

    localparam logic [1:0] REQ_NOP       = 2'd0;
    localparam logic [1:0] REQ_ACTIVE    = 2'd1;
    localparam logic [1:0] REQ_LINKRESET = 2'd2;
    localparam logic [1:0] REQ_RETRAIN   = 2'd3;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_state;
    logic       rdi_valid;
    logic       ovf_in;
    logic       buf_en, buf_flush, req_ack, req_nak, ovf_out;
    logic [2:0] status;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] vec;   // {ack, nak, flush, status[2:0], enable, overflow}
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [7:0] obs;
    logic [4:0] view;
    assign obs  = {req_ack, req_nak, buf_flush, status, buf_en, ovf_out};
    assign view = {status, buf_en, ovf_out};

    ucie_ctl_rx_link_ctrl #(
        .DRAIN_IDLE     (4),
        .DRAIN_TIMEOUT  (64),
        .RETRAIN_CYCLES (16)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_req_valid         (req_valid),
        .i_req_state         (req_state),
        .i_rdi_pl_valid      (rdi_valid),
        .i_overflow_detected (ovf_in),
        .o_buffer_enable     (buf_en),
        .o_buffer_flush      (buf_flush),
        .o_req_ack           (req_ack),
        .o_req_nak           (req_nak),
        .o_state_status      (status),
        .o_overflow_detected (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expected pulse: ack, nak, flush, status, enable, sticky flag.
    task automatic expect_pulse(input logic a, input logic n, input logic f,
                                input logic [2:0] st, input logic en, input logic ov,
                                input string tag);
        exp_t e;
        e.vec = {a, n, f, st, en, ov};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Drive one request for exactly one sampling edge; call at a falling edge.
    task automatic req(input logic [1:0] s);
        req_valid = 1'b1;
        req_state = s;
        @(negedge clk);
        req_valid = 1'b0;
        req_state = REQ_NOP;
    endtask

    task automatic chk_view(input string name, input logic [4:0] want);
        checks++;
        if (view !== want) begin
            failures++;
            $display("FAIL %s actual={st,en,ovf}=%b required=%b", name, view, want);
        end
    endtask

    task automatic chk_obs(input string name, input logic [7:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, obs, want);
        end
    endtask

    // Scoreboard monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (req_ack || req_nak || buf_flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse actual=%b required=no pulse", obs);
            end else begin
                mon_e = exp_q.pop_front();
                if (obs !== mon_e.vec) begin
                    failures++;
                    $display("FAIL %s actual=%b required=%b", mon_e.tag, obs, mon_e.vec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_state = REQ_NOP;
        rdi_valid = 1'b0;
        ovf_in    = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_obs("reset_outputs", 8'b000_000_0_0);
        rst = 1'b1;

        // 1: RESET -> ACTIVE -> DRAIN (idle) -> RETRAIN -> ACTIVE
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "t1_ack_active");
        req(REQ_ACTIVE);
        chk_view("t1_active", {3'd1, 1'b1, 1'b0});
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "t1_ack_retrain");
        req(REQ_RETRAIN);
        expect_pulse(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, "t1_flush");
        repeat (3) @(negedge clk);
        chk_view("t1_drain_3idle", {3'd2, 1'b1, 1'b0});
        @(negedge clk);
        chk_view("t1_retrain", {3'd3, 1'b0, 1'b0});
        repeat (15) @(negedge clk);
        chk_view("t1_retrain_last", {3'd3, 1'b0, 1'b0});
        @(negedge clk);
        chk_view("t1_back_active", {3'd1, 1'b1, 1'b0});
        req(REQ_NOP);
        chk_view("t1_nop_no_change", {3'd1, 1'b1, 1'b0});

        // 2: LINKRESET drain where traffic restarts the idle count
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "t2_ack_linkreset");
        req(REQ_LINKRESET);
        repeat (2) @(negedge clk);
        rdi_valid = 1'b1;
        repeat (3) @(negedge clk);
        rdi_valid = 1'b0;
        expect_pulse(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "t2_flush");
        repeat (3) @(negedge clk);
        chk_view("t2_drain_restarted", {3'd2, 1'b1, 1'b0});
        @(negedge clk);
        chk_view("t2_reset", {3'd0, 1'b0, 1'b0});

        // 3: drain timeout with traffic never stopping
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "t3_ack_active");
        req(REQ_ACTIVE);
        rdi_valid = 1'b1;
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "t3_ack_retrain");
        req(REQ_RETRAIN);
        repeat (63) @(negedge clk);
        chk_view("t3_drain_63", {3'd2, 1'b1, 1'b0});
        @(negedge clk);
        chk_view("t3_linkerror", {3'd4, 1'b0, 1'b1});
        rdi_valid = 1'b0;

        // 4: overflow beats a same-cycle request; LINKERROR exit
        expect_pulse(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "t4_exit_err_a");
        req(REQ_LINKRESET);
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "t4_ack_active");
        req(REQ_ACTIVE);
        ovf_in = 1'b1;
        req(REQ_RETRAIN);
        ovf_in = 1'b0;
        chk_view("t4_ovf_linkerror", {3'd4, 1'b0, 1'b1});
        expect_pulse(1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, "t4_nak_active");
        req(REQ_ACTIVE);
        expect_pulse(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "t4_exit_err_b");
        req(REQ_LINKRESET);
        chk_view("t4_reset", {3'd0, 1'b0, 1'b0});

        // 5: naks from RESET and RETRAIN, LINKRESET abort of RETRAIN
        expect_pulse(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, "t5_nak_reset");
        req(REQ_RETRAIN);
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "t5_ack_active");
        req(REQ_ACTIVE);
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "t5_ack_retrain");
        req(REQ_RETRAIN);
        expect_pulse(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, "t5_flush");
        repeat (4) @(negedge clk);
        chk_view("t5_retrain", {3'd3, 1'b0, 1'b0});
        expect_pulse(1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, "t5_nak_retrain");
        req(REQ_ACTIVE);
        expect_pulse(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "t5_abort");
        req(REQ_LINKRESET);
        chk_view("t5_reset", {3'd0, 1'b0, 1'b0});

        // 6: asynchronous reset in the middle of RETRAIN
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "t6_ack_active");
        req(REQ_ACTIVE);
        expect_pulse(1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "t6_ack_retrain");
        req(REQ_RETRAIN);
        expect_pulse(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, "t6_flush");
        repeat (4) @(negedge clk);
        repeat (8) @(negedge clk);
        chk_view("t6_retrain_8", {3'd3, 1'b0, 1'b0});
        #2 rst = 1'b0;
        #1 chk_obs("t6_async_reset", 8'b000_000_0_0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_obs("t6_after_release", 8'b000_000_0_0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
